// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// 32 lines of 256 bits (8 words). Tag, valid, dirty and line data live inside the block.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | serving hits; a miss is detected here
// WRITEBACK  | dirty victim line being written to memory, waits for ack
// ALLOCATE   | missing line being fetched from memory, waits for ack
// REFILLED   | line installed; one bubble cycle, then the access replays
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   cpu_req_i, cpu_write_i  CPU access valid / store select
//   cpu_addr_i, cpu_data_i  byte address and store data
//   cpu_data_o, cpu_stall_o load data (zero unless read hit), pipeline stall
//   mem_enable_o, mem_write_o, mem_addr_o, mem_data_o  line request to memory
//   mem_data_i, mem_ack_i   fetched line and one-cycle completion pulse
module dcache_ctrl (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_REFILLED  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [255:0] data_q [32];
  logic [21:0]  tag_q  [32];
  logic [31:0]  valid_q, valid_d;
  logic [31:0]  dirty_q, dirty_d;

  // Line address (tag + index) of the access that missed; drives the
  // memory transaction so CPU address changes mid-miss cannot disturb it.
  logic [26:0]  miss_addr_q, miss_addr_d;

  logic [4:0]   cur_idx;
  logic [21:0]  cur_tag;
  logic [2:0]   cur_word;
  logic [4:0]   miss_idx;
  logic         hit;

  logic         line_we;
  logic [4:0]   line_widx;
  logic [255:0] line_wdata;
  logic         tag_we;
  logic [21:0]  tag_wdata;

  // Byte offset bits are architecturally ignored.
  logic         unused_byte_bits;
  assign unused_byte_bits = ^cpu_addr_i[1:0];

  assign cur_idx  = cpu_addr_i[9:5];
  assign cur_tag  = cpu_addr_i[31:10];
  assign cur_word = cpu_addr_i[4:2];
  assign miss_idx = miss_addr_q[4:0];

  assign hit = (state_q == S_IDLE) && cpu_req_i && valid_q[cur_idx] &&
               (tag_q[cur_idx] == cur_tag);

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    line_we      = 1'b0;
    line_widx    = cur_idx;
    line_wdata   = data_q[cur_idx];
    tag_we       = 1'b0;
    tag_wdata    = cur_tag;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'd0;
    mem_data_o   = 256'd0;
    cpu_data_o   = 32'd0;
    cpu_stall_o  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          if (cpu_write_i) begin
            line_we = 1'b1;
            line_wdata[{cur_word, 5'b0} +: 32] = cpu_data_i;
            dirty_d[cur_idx] = 1'b1;
          end else begin
            cpu_data_o = data_q[cur_idx][{cur_word, 5'b0} +: 32];
          end
        end else if (cpu_req_i) begin
          cpu_stall_o = 1'b1;
          miss_addr_d = cpu_addr_i[31:5];
          if (valid_q[cur_idx] && dirty_q[cur_idx])
            state_d = S_WRITEBACK;
          else
            state_d = S_ALLOCATE;
        end
      end

      S_WRITEBACK: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[miss_idx], miss_idx, 5'b0};
        mem_data_o   = data_q[miss_idx];
        if (mem_ack_i)
          state_d = S_ALLOCATE;
      end

      S_ALLOCATE: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {miss_addr_q, 5'b0};
        if (mem_ack_i) begin
          line_we            = 1'b1;
          line_widx          = miss_idx;
          line_wdata         = mem_data_i;
          tag_we             = 1'b1;
          tag_wdata          = miss_addr_q[26:5];
          valid_d[miss_idx]  = 1'b1;
          dirty_d[miss_idx]  = 1'b0;
          state_d            = S_REFILLED;
        end
      end

      S_REFILLED: begin
        cpu_stall_o = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      valid_q     <= 32'd0;
      dirty_q     <= 32'd0;
      miss_addr_q <= 27'd0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // Tag and data storage are not reset; valid bits qualify them. Writes are
  // still blocked during reset so an abandoned fill cannot land.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (line_we)
        data_q[line_widx] <= line_wdata;
      if (tag_we)
        tag_q[line_widx] <= tag_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_write_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  int n_cmp = 0;
  int n_err = 0;

  dcache_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cpu_req_i    (cpu_req_i),
    .cpu_write_i  (cpu_write_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_data_i   (cpu_data_i),
    .cpu_data_o   (cpu_data_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic req, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    cpu_req_i   = req;
    cpu_write_i = wr;
    cpu_addr_i  = addr;
    cpu_data_i  = data;
  endtask

  logic [255:0] line_a, line_b, line_c;
  int stall_cnt;

  initial begin
    line_a = {8{32'h01010101}};
    line_a[63:32] = 32'hDEADBEEF;
    line_b = {8{32'h02020202}};
    line_b[63:32] = 32'hCAFEF00D;
    line_c = {8{32'h03030303}};
    line_c[63:32] = 32'h55AA55AA;

    rst_i = 1'b1;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    step();
    step();
    rst_i = 1'b0;
    #1;

    // reset state
    chk("rst_mem_enable", mem_enable_o, 0);
    chk("rst_mem_write", mem_write_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_data", mem_data_o, 0);
    chk("rst_stall_noreq", cpu_stall_o, 0);
    chk("rst_cpu_data", cpu_data_o, 0);

    // cold load 0x404, ack during the 10th cycle after the miss
    drive(1'b1, 1'b0, 32'h0000_0404, 32'd0);
    stall_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      mem_ack_i  = (c == 10);
      mem_data_i = line_a;
      #1;
      if (c == 2) begin
        chk("cold_alloc_enable", mem_enable_o, 1);
        chk("cold_alloc_write", mem_write_o, 0);
        chk("cold_alloc_addr", mem_addr_o, 32'h0000_0400);
      end
      if (!cpu_stall_o) break;
      stall_cnt++;
      step();
    end
    mem_ack_i = 1'b0;
    chk("cold_stall_cycles", stall_cnt, 12);
    chk("cold_load_data", cpu_data_o, 32'hDEADBEEF);
    chk("cold_enable_after", mem_enable_o, 0);

    // store hit then load hit
    step();
    drive(1'b1, 1'b1, 32'h0000_0404, 32'h11223344);
    #1;
    chk("store_hit_stall", cpu_stall_o, 0);
    chk("store_hit_rdata", cpu_data_o, 0);
    step();
    drive(1'b1, 1'b0, 32'h0000_0404, 32'd0);
    #1;
    chk("load_after_store_stall", cpu_stall_o, 0);
    chk("load_after_store_data", cpu_data_o, 32'h11223344);
    drive(1'b1, 1'b0, 32'h0000_0400, 32'd0);
    #1;
    chk("other_word_kept", cpu_data_o, 32'h01010101);

    // dirty conflict miss 0x8404
    step();
    drive(1'b1, 1'b0, 32'h0000_8404, 32'd0);
    #1;
    chk("dirty_miss_stall", cpu_stall_o, 1);
    chk("dirty_miss_idle_enable", mem_enable_o, 0);
    step();
    chk("wb_enable", mem_enable_o, 1);
    chk("wb_write", mem_write_o, 1);
    chk("wb_addr", mem_addr_o, 32'h0000_0400);
    chk("wb_word1", mem_data_o[63:32], 32'h11223344);
    chk("wb_word0", mem_data_o[31:0], 32'h01010101);
    step();
    cpu_addr_i = 32'h0000_0040;
    #1;
    chk("wb_addr_hold", mem_addr_o, 32'h0000_0400);
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    cpu_addr_i = 32'h0000_8404;
    #1;
    chk("alloc_enable", mem_enable_o, 1);
    chk("alloc_write", mem_write_o, 0);
    chk("alloc_addr", mem_addr_o, 32'h0000_8400);
    chk("alloc_mem_data", mem_data_o, 0);
    mem_ack_i  = 1'b1;
    mem_data_i = line_b;
    step();
    mem_ack_i = 1'b0;
    #1;
    chk("refilled_enable", mem_enable_o, 0);
    chk("refilled_stall", cpu_stall_o, 1);
    step();
    chk("dirty_miss_done_stall", cpu_stall_o, 0);
    chk("dirty_miss_data", cpu_data_o, 32'hCAFEF00D);

    // fill index 1 (clean miss, fast ack)
    step();
    drive(1'b1, 1'b0, 32'h0000_0024, 32'd0);
    #1;
    chk("idx1_miss_stall", cpu_stall_o, 1);
    step();
    mem_ack_i  = 1'b1;
    mem_data_i = line_c;
    step();
    mem_ack_i = 1'b0;
    step();
    chk("idx1_fill_data", cpu_data_o, 32'h55AA55AA);

    // back-to-back read hit / write hit on different indices
    step();
    drive(1'b1, 1'b0, 32'h0000_8404, 32'd0);
    #1;
    chk("b2b_read_stall", cpu_stall_o, 0);
    chk("b2b_read_data", cpu_data_o, 32'hCAFEF00D);
    chk("b2b_read_enable", mem_enable_o, 0);
    step();
    drive(1'b1, 1'b1, 32'h0000_0024, 32'h0BADCAFE);
    #1;
    chk("b2b_write_stall", cpu_stall_o, 0);
    chk("b2b_write_enable", mem_enable_o, 0);
    step();
    drive(1'b1, 1'b0, 32'h0000_0024, 32'd0);
    #1;
    chk("b2b_readback", cpu_data_o, 32'h0BADCAFE);

    // spurious acks while idle
    step();
    drive(1'b0, 1'b0, 32'h0000_0024, 32'd0);
    mem_ack_i  = 1'b1;
    mem_data_i = {256{1'b1}};
    #1;
    chk("spur_stall", cpu_stall_o, 0);
    chk("spur_enable", mem_enable_o, 0);
    step();
    step();
    mem_ack_i = 1'b0;
    drive(1'b1, 1'b0, 32'h0000_8404, 32'd0);
    #1;
    chk("spur_hit_idx0_stall", cpu_stall_o, 0);
    chk("spur_hit_idx0_data", cpu_data_o, 32'hCAFEF00D);
    drive(1'b1, 1'b0, 32'h0000_0024, 32'd0);
    #1;
    chk("spur_hit_idx1_data", cpu_data_o, 32'h0BADCAFE);

    // reset during ALLOCATE, late ack ignored
    step();
    drive(1'b1, 1'b0, 32'h0000_0040, 32'd0);
    #1;
    chk("rstalloc_miss_stall", cpu_stall_o, 1);
    step();
    chk("rstalloc_enable", mem_enable_o, 1);
    chk("rstalloc_addr", mem_addr_o, 32'h0000_0040);
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 32'h0000_0040, 32'd0);
    step();
    rst_i = 1'b0;
    #1;
    chk("after_rst_enable", mem_enable_o, 0);
    chk("after_rst_stall", cpu_stall_o, 0);
    step();
    step();
    mem_ack_i  = 1'b1;
    mem_data_i = line_a;
    #1;
    chk("late_ack_enable", mem_enable_o, 0);
    step();
    mem_ack_i = 1'b0;
    #1;
    chk("late_ack_stall", cpu_stall_o, 0);
    drive(1'b1, 1'b0, 32'h0000_0040, 32'd0);
    #1;
    chk("post_rst_same_addr_miss", cpu_stall_o, 1);
    chk("post_rst_same_addr_data", cpu_data_o, 0);
    drive(1'b1, 1'b0, 32'h0000_8404, 32'd0);
    #1;
    chk("post_rst_idx0_miss", cpu_stall_o, 1);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
